// File: rtl/multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_pkg
// Brief    : Shared constants, state encoding and helpers for the
//            shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package multiplier_pkg;

  // Default operand width
  localparam int unsigned MULT_WIDTH = 32;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

  // Initial value of the step counter: one step per operand bit,
  // and the last step is taken with the counter at zero
  function automatic int unsigned cycle_last(input int unsigned width);
    return width - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_step.sv
`default_nettype none
// ============================================================================
// Module   : mult_step
// Brief    : One combinational shift-add step of an unsigned multiplier.
//            The low half of the product register holds the remaining
//            multiplier bits; its LSB selects whether mcand is added.
// Revision : 1.0 - initial release
// ============================================================================
module mult_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic [WIDTH-1:0]   i_mcand,
  output logic [2*WIDTH-1:0] o_prod
);

  // Carry out of the add is kept so no product bit is lost
  logic [WIDTH:0] w_addend;
  logic [WIDTH:0] w_sum;

  // Add mcand into the high half when the current multiplier bit is set,
  // then shift the whole product right by one
  always_comb begin
    w_addend = i_prod[0] ? {1'b0, i_mcand} : '0;
    w_sum    = {1'b0, i_prod[2*WIDTH-1:WIDTH]} + w_addend;
    o_prod   = {w_sum, i_prod[WIDTH-1:1]};
  end

endmodule
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// Module   : multiplier
// Brief    : Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
//            Load on start in IDLE, WIDTH shift-add steps in RUN, then hold
//            the result in DONE while start stays high.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Ph,
  output logic             ok,
  output logic             ovf
);

  localparam int unsigned          CNT_W        = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     c_cycle_last = CNT_W'(cycle_last(WIDTH));

  mult_state_t          r_state;
  mult_state_t          w_state_nxt;
  logic [2*WIDTH-1:0]   r_prod;
  logic [2*WIDTH-1:0]   w_prod_nxt;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     w_mcand_nxt;
  logic [CNT_W-1:0]     r_cycle;
  logic [CNT_W-1:0]     w_cycle_nxt;
  logic [2*WIDTH-1:0]   w_step;

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_prod  (r_prod),
    .i_mcand (r_mcand),
    .o_prod  (w_step)
  );

  // Next-state and next-datapath decode; dropping start anywhere clears all
  always_comb begin
    w_state_nxt = r_state;
    w_prod_nxt  = r_prod;
    w_mcand_nxt = r_mcand;
    w_cycle_nxt = r_cycle;
    case (r_state)
      ST_IDLE: begin
        w_prod_nxt  = '0;
        w_mcand_nxt = '0;
        w_cycle_nxt = '0;
        if (start) begin
          w_state_nxt = ST_RUN;
          w_prod_nxt  = {{WIDTH{1'b0}}, B};
          w_mcand_nxt = A;
          w_cycle_nxt = c_cycle_last;
        end
      end
      ST_RUN: begin
        if (!start) begin
          w_state_nxt = ST_IDLE;
          w_prod_nxt  = '0;
          w_mcand_nxt = '0;
          w_cycle_nxt = '0;
        end else begin
          w_prod_nxt  = w_step;
          w_cycle_nxt = r_cycle - 1'b1;
          if (r_cycle == '0) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!start) begin
          w_state_nxt = ST_IDLE;
          w_prod_nxt  = '0;
          w_mcand_nxt = '0;
          w_cycle_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_prod_nxt  = '0;
        w_mcand_nxt = '0;
        w_cycle_nxt = '0;
      end
    endcase
  end

  // State, product, multiplicand and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_prod  <= '0;
      r_mcand <= '0;
      r_cycle <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prod  <= w_prod_nxt;
      r_mcand <= w_mcand_nxt;
      r_cycle <= w_cycle_nxt;
    end
  end

  assign P   = r_prod[WIDTH-1:0];
  assign Ph  = r_prod[2*WIDTH-1:WIDTH];
  assign ok  = (r_state == ST_DONE);
  assign ovf = ok & (|Ph);

endmodule
`default_nettype wire

// File: tb/tb_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier
// Brief    : Self-checking bench for multiplier; expected products come from
//            plain 64-bit arithmetic, expected latency from the edge count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] P;
  logic [31:0] Ph;
  logic        ok;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  multiplier #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .Ph    (Ph),
    .ok    (ok),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Outputs all zero, as after reset or an abort
  task automatic chk_idle(input string tag);
    chk({tag, "_P"},   64'(P),   64'd0);
    chk({tag, "_Ph"},  64'(Ph),  64'd0);
    chk({tag, "_ok"},  64'(ok),  64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  // Full transaction: load, wait for ok (bounded), check result and
  // latency, hold in DONE with moving operands, then release start
  task automatic run_product(input logic [31:0] a, input logic [31:0] b,
                             input bit scramble, input string tag);
    logic [63:0] exp_p;
    int          n;
    bit          seen;
    exp_p = {32'd0, a} * {32'd0, b};
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    n     = 0;
    seen  = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (ok) seen = 1'b1;
      else if (scramble) begin
        A = $urandom;
        B = $urandom;
      end
    end
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_prod"}, {Ph, P}, exp_p);
    chk({tag, "_ovf"}, 64'(ovf), 64'(|exp_p[63:32]));
    for (int i = 0; i < 3; i++) begin
      A = $urandom;
      B = $urandom;
      @(posedge clk);
      #1;
    end
    chk({tag, "_hold_ok"}, 64'(ok), 64'd1);
    chk({tag, "_hold_prod"}, {Ph, P}, exp_p);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk_idle({tag, "_release"});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    reset = 1'b0;

    // Directed corner products
    run_product(32'd3, 32'd5, 1'b0, "small");
    run_product(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "max");
    run_product(32'h00010000, 32'h00010000, 1'b0, "pow2");
    run_product(32'd0, 32'h12345678, 1'b0, "zero");

    // Abort after ten RUN steps
    @(negedge clk);
    A     = 32'hDEADBEEF;
    B     = 32'h12345;
    start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    chk("abort_pre_ok", 64'(ok), 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk_idle("abort");
    run_product(32'd7, 32'd6, 1'b0, "after_abort");

    // Reset pulse at step 20 while start stays high
    @(negedge clk);
    A     = 32'hCAFEF00D;
    B     = 32'h0BADC0DE;
    start = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("rst_mid");
    reset = 1'b0;
    run_product(32'h89ABCDEF, 32'h00FF00FF, 1'b0, "after_rst");

    // Random operands, changed every cycle after load
    for (int k = 0; k < 6; k++) begin
      run_product($urandom, $urandom, 1'b1, "rand");
    end
    run_product($urandom_range(0, 255), $urandom_range(0, 255), 1'b1, "rand_small");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk, input, 1, rising-edge clock; reset, input, 1, synchronous active-high reset.
REQ-002 SHALL have parameter WIDTH, default 32, operand width; all widths below follow WIDTH.
REQ-003 SHALL have start, input, 1: held high to request and hold a product; low aborts or releases.
REQ-004 SHALL have A, input, 32: multiplicand, unsigned.
REQ-005 SHALL have B, input, 32: multiplier, unsigned.
REQ-006 SHALL have P, output, 32: low 32 bits of the product.
REQ-007 SHALL have Ph, output, 32: high 32 bits of the product.
REQ-008 SHALL have ok, output, 1: high when P/Ph hold the final product.
REQ-009 SHALL have ovf, output, 1: high when ok=1 and Ph!=0, meaning the product does not fit in 32 bits.

Function
REQ-010 SHALL implement a three-state machine: IDLE, RUN, DONE.
REQ-011 SHALL stay in IDLE while start=0, with the product register, multiplicand register and cycle counter held at 0.
REQ-012 SHALL, on an edge in IDLE with start=1, load mcand<=A, {Ph,P}<={32'h0,B}, cycle<=31, and go to RUN.
REQ-013 SHALL perform one shift-add step per RUN edge: sum[32:0]={1'b0,Ph}+(P[0]?mcand:0); {Ph,P}<={sum,P[31:1]}.
REQ-014 SHALL decrement cycle on each RUN step and go to DONE on the step taken with cycle==0 (exactly 32 steps).
REQ-015 SHALL raise ok exactly 33 rising edges after the first edge that samples start=1 in IDLE.
REQ-016 SHALL hold ok=1 and a stable {Ph,P} in DONE for as long as start=1; A/B changes in DONE SHALL be ignored.
REQ-017 SHALL return to IDLE and clear all registers on the edge that samples start=0 in RUN or DONE; a new product requires start to be seen high again in IDLE.
REQ-018 SHALL keep ok=0 in IDLE and RUN; {Ph,P} SHALL show partial state during RUN and SHALL NOT be used by consumers until ok=1.
REQ-019 SHALL sample A and B only at the IDLE->RUN load edge; operand changes during RUN SHALL NOT affect the result.
REQ-020 SHALL drive ovf=|Ph only when ok=1, and ovf=0 otherwise.
REQ-021 SHALL produce the exact 64-bit unsigned product with no truncation of the step carry (33-bit sum).

Reset
REQ-022 SHALL, on an edge with reset=1, enter IDLE and set P=0, Ph=0, ok=0, ovf=0, cycle=0, mcand=0, regardless of state or start.
REQ-023 SHALL give reset priority over start when both are high on the same edge; the load occurs on the first later edge with reset=0 and start=1.
REQ-024 SHALL abort any in-flight RUN when reset asserts, with no partial result reported.

Structure
REQ-025 SHALL keep WIDTH, the cycle-count constant (WIDTH-1) and the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) in the shared calculator constants include.
REQ-026 SHALL use one sub-module, mult_step: combinational, taking {Ph,P} and mcand and returning the next {Ph,P} per REQ-013; the FSM, counter and registers stay in multiplier.
REQ-027 SHALL use a 5-bit cycle counter for WIDTH=32 ($clog2(WIDTH) bits in general).

Verification
REQ-028 SHALL test A=3, B=5, start held high: ok rises at edge 33, P=15, Ph=0, ovf=0.
REQ-029 SHALL test A=B=32'hFFFFFFFF: Ph=32'hFFFFFFFE, P=32'h00000001, ovf=1.
REQ-030 SHALL test A=32'h00010000, B=32'h00010000: Ph=1, P=0, ovf=1; also A=0, B=32'h12345678 -> P=0, Ph=0, ovf=0.
REQ-031 SHALL test start dropped after 10 RUN steps: next edge IDLE, P=Ph=0, ok=0; start reasserted with A=7, B=6 -> P=42 after 33 more edges.
REQ-032 SHALL test reset pulsed for one edge at step 20 with start still high: IDLE with all outputs 0, then a fresh load on the next edge and ok 33 edges after that load-sampling edge.
REQ-033 SHALL test A/B changed every cycle during RUN and DONE: the result equals the product of the values sampled at the load edge.
